feedback_loop_arbiter: RTL



---
 rtl/feedback_loop_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/feedback_loop_arbiter.sv
// Round-robin front end that time-shares one wrapping accumulate datapath among NCH requesters.
// Each channel keeps its own state in a local register bank; the result is returned with its channel.
module feedback_loop_arbiter #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned CW  = $clog2(NCH)
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic [NCH-1:0]   req_valid,
    input  logic [NCH*W-1:0] req_data,
    output logic [NCH-1:0]   req_ready,
    input  logic [NCH-1:0]   clear,
    output logic             out_valid,
    output logic [CW-1:0]    out_ch,
    output logic [W-1:0]     out_data,
    input  logic             out_ready
);

    logic [NCH-1:0][W-1:0] acc_q, acc_d;
    logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         out_ch_q, out_ch_d;
    logic [W-1:0]          out_data_q, out_data_d;

    logic          stall;
    logic          grant_any;
    logic [CW-1:0] grant_ch;
    logic [CW:0]   idx;
    logic          accept;
    logic [W-1:0]  sample;
    logic [W-1:0]  base;
    logic [W-1:0]  sum;

    assign stall = out_valid_q & ~out_ready;

    // Rotating priority search starting at rr_ptr, wrapping modulo NCH.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (idx >= (CW+1)'(NCH)) begin
                idx = idx - (CW+1)'(NCH);
            end
            if (!grant_any && req_valid[idx[CW-1:0]]) begin
                grant_any = 1'b1;
                grant_ch  = idx[CW-1:0];
            end
        end
    end

    assign accept = grant_any & ~stall & system1000_rstn;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_ch] = 1'b1;
        end
    end

    // Clear on the granted channel wins over its stored state, so the result is just the sample.
    always_comb begin
        sample = '0;
        base   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_ch == CW'(i)) begin
                sample = req_data[i*W +: W];
                base   = clear[i] ? '0 : acc_q[i];
            end
        end
        sum = base + sample;
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            acc_d[i] = acc_q[i];
            if (clear[i]) begin
                acc_d[i] = '0;
            end
            if (accept && (grant_ch == CW'(i))) begin
                acc_d[i] = sum;
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            out_valid_d = accept;
            if (accept) begin
                out_ch_d   = grant_ch;
                out_data_d = sum;
                rr_ptr_d   = (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            acc_q       <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule
